fm_phase_gen: RTL and testbench
===============================

FM_PHASE_GEN -- requirements
Module: fm_phase_gen

Interface
REQ-001 Parameter NUM_OPS, default 36: number of operator phase accumulators.
REQ-002 Parameter PHASE_BITS, default 19: accumulator width.
REQ-003 Parameter OUT_BITS, default 10: phase output width, taken from the accumulator MSBs.
REQ-004 Parameter VIB_DIV_LOG2, default 10: log2 of frame ticks per vibrato step.
REQ-005 Derived constant IDX_BITS = clog2(NUM_OPS).
REQ-006 Port clk, input, 1: sole clock.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port frame_tick, input, 1: one-cycle pulse per output sample frame.
REQ-009 Port in_valid, input, 1: operator update request.
REQ-010 Port in_idx, input, IDX_BITS: operator index.
REQ-011 Port restart, input, 1: on key-on, zero the phase before adding the increment.
REQ-012 Ports block (3 bits), fnum (10 bits), mult (4 bits), vib (1 bit) and dvb (1 bit), inputs: operator pitch parameters, qualified by in_valid.
REQ-013 Port ready, output, 1: high when updates are accepted.
REQ-014 Port out_valid, output, 1: out_phase and out_idx are valid.
REQ-015 Port out_idx, output, IDX_BITS: index of the returned operator.
REQ-016 Port out_phase, output, OUT_BITS: pre-update phase, equal to acc[PHASE_BITS-1 -: OUT_BITS].
REQ-017 Port vib_pos, output, 3: current vibrato position.

Function
REQ-018 The block SHALL have two states, INIT and RUN; INIT is entered on reset.
REQ-019 In INIT, the block SHALL write 0 to accumulators 0 to NUM_OPS-1 over NUM_OPS cycles, then enter RUN; ready=0 throughout INIT.
REQ-020 in_valid while ready=0 SHALL be ignored, with no writes and no out_valid.
REQ-021 Vibrato range SHALL be computed as follows:
- start with fnum[9:7];
- if vib=0 or vib_pos[1:0]=0, range=0;
- otherwise, if vib_pos[0]=1, shift range right by 1;
- if dvb=0, shift range right by 1 again.
REQ-022 The vibrato-adjusted f_num SHALL be fnum-range when vib_pos[2]=1, else fnum+range, modulo 2^10.
REQ-023 mult 0..15 SHALL map to multiplier 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
REQ-024 The phase increment SHALL be computed as follows:
- fw = f_num<<block, 17 bits;
- inc = ((fw>>1)*multiplier)>>1;
- inc is truncated to PHASE_BITS.
REQ-025 The pipeline SHALL have two stages:
- stage 0 (cycle of in_valid): compute inc; register inc, idx and restart; issue the synchronous RAM read;
- stage 1: new = (restart ? 0 : q) + inc, modulo 2^PHASE_BITS; write new at idx.
REQ-026 out_valid, out_idx and out_phase SHALL be registered, with out_valid asserted exactly 2 cycles after an accepted in_valid.
REQ-027 out_phase SHALL be derived from the pre-update q, or 0 if restart was set.
REQ-028 Throughput SHALL be one update per cycle.
REQ-029 Stage 0 and stage 1 SHALL see a consistent accumulator value when consecutive requests target the same idx: if stage 0 idx equals the stage 1 write idx, stage 0 SHALL use the forwarded new value instead of the stale RAM data.
REQ-030 A divider counter SHALL count frame_tick pulses; each 2^VIB_DIV_LOG2 ticks it SHALL wrap and increment vib_pos, which wraps 7 to 0.
REQ-031 frame_tick SHALL be honoured in both INIT and RUN, including when coincident with in_valid.
REQ-032 An accumulator at 2^PHASE_BITS-1 plus any nonzero inc SHALL wrap modulo 2^PHASE_BITS, with no saturation.

Reset
REQ-033 While reset is asserted, the following SHALL hold:
- state=INIT, init counter=0;
- ready=0, out_valid=0, out_idx=0, out_phase=0;
- vib_pos=0, divider=0;
- pipeline valid bits=0.
REQ-034 A reset asserted mid-INIT or mid-RUN SHALL discard in-flight updates and restart the full INIT sweep.
REQ-035 RAM contents SHALL NOT be cleared by reset itself, only by the INIT sweep.

Structure
REQ-036 The multiplier table and the vibrato range function SHALL reside in shared package fm_pkg, which is also used by envelope and operator blocks.
REQ-037 Accumulator storage SHALL be the sub-module fm_phase_ram: synchronous-read, one write port, NUM_OPS x PHASE_BITS, no reset.

Verification
REQ-038 Increment: reset released, wait for ready, then send fnum=0x200, block=4, mult=1, vib=0, idx=3 on 5 consecutive cycles. Required: inc=0x1000; out_phase=0,8,16,24,32; accumulator=0x5000 afterwards.
REQ-039 Vibrato: with fnum=0x380, vib=1, dvb=1, mult=0, block=0, step vib_pos through 0..7 (1024 frame_ticks per step). Required f_num per position: 0x380,0x383,0x387,0x383,0x380,0x37D,0x379,0x37D. With dvb=0 the offsets are 0,1,3,1,0,-1,-3,-1.
REQ-040 Restart: a request for idx 5 with restart=1 and inc=0x40 SHALL yield out_phase=0 and accumulator=0x40.
REQ-041 Hazard: requests for idx 7 on 3 back-to-back cycles with inc=0x200 SHALL produce out_phase 0,1,2, matching the results of spaced-out requests.
REQ-042 Wrap and reset: preload an accumulator to 0x7FFFF, then add inc=1. Required: out_phase=0x3FF and accumulator=0. Then assert reset mid-RUN and confirm: ready=0 for NUM_OPS cycles, all accumulators read 0, vib_pos=0.

Source files
------------

// File: rtl/fm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_pkg: pitch helpers shared by phase, envelope and operator blocks.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fm_pkg;

  localparam int FNUM_BITS  = 10;
  localparam int BLOCK_BITS = 3;
  localparam int MULT_BITS  = 4;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } phase_state_e;

  function automatic logic [4:0] mult_factor(input logic [MULT_BITS-1:0] mult);
    logic [4:0] m;
    case (mult)
      4'd0:    m = 5'd1;
      4'd1:    m = 5'd2;
      4'd2:    m = 5'd4;
      4'd3:    m = 5'd6;
      4'd4:    m = 5'd8;
      4'd5:    m = 5'd10;
      4'd6:    m = 5'd12;
      4'd7:    m = 5'd14;
      4'd8:    m = 5'd16;
      4'd9:    m = 5'd18;
      4'd10:   m = 5'd20;
      4'd11:   m = 5'd20;
      4'd12:   m = 5'd24;
      4'd13:   m = 5'd24;
      default: m = 5'd30;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] vib_range(input logic [2:0] fnum_hi, input logic vib,
                                           input logic dvb, input logic [2:0] vib_pos);
    logic [2:0] r;
    r = fnum_hi;
    if (!vib || vib_pos[1:0] == 2'b00) r = 3'd0;
    else if (vib_pos[0]) r = r >> 1;
    if (!dvb) r = r >> 1;
    return r;
  endfunction

  // Upper half of the vibrato cycle bends pitch downwards.
  function automatic logic [FNUM_BITS-1:0] vib_fnum(input logic [FNUM_BITS-1:0] fnum,
                                                    input logic vib, input logic dvb,
                                                    input logic [2:0] vib_pos);
    logic [2:0] r;
    r = vib_range(fnum[9:7], vib, dvb, vib_pos);
    return vib_pos[2] ? (fnum - FNUM_BITS'(r)) : (fnum + FNUM_BITS'(r));
  endfunction

  function automatic logic [20:0] phase_inc(input logic [FNUM_BITS-1:0] fnum,
                                            input logic [BLOCK_BITS-1:0] block,
                                            input logic [MULT_BITS-1:0] mult);
    logic [21:0] fw;
    logic [21:0] prod;
    fw   = 22'(fnum) << block;
    prod = (fw >> 1) * 22'(mult_factor(mult));
    return 21'(prod >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fm_phase_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_phase_gen_if: operator update request / phase result bus.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fm_phase_gen_if #(
  parameter int NUM_OPS  = 36,
  parameter int OUT_BITS = 10,
  localparam int IDX_BITS = $clog2(NUM_OPS)
);
  logic                in_valid;
  logic [IDX_BITS-1:0] in_idx;
  logic                restart;
  logic [2:0]          block;
  logic [9:0]          fnum;
  logic [3:0]          mult;
  logic                vib;
  logic                dvb;
  logic                ready;
  logic                out_valid;
  logic [IDX_BITS-1:0] out_idx;
  logic [OUT_BITS-1:0] out_phase;

  modport master (
    output in_valid, in_idx, restart, block, fnum, mult, vib, dvb,
    input  ready, out_valid, out_idx, out_phase
  );

  modport slave (
    input  in_valid, in_idx, restart, block, fnum, mult, vib, dvb,
    output ready, out_valid, out_idx, out_phase
  );
endinterface
`default_nettype wire

// File: rtl/fm_phase_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_phase_ram: accumulator store, one write port, synchronous read.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fm_phase_ram #(
  parameter int DEPTH     = 36,
  parameter int WIDTH     = 19,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read-before-write on an address collision; the caller forwards.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule
`default_nettype wire

// File: rtl/fm_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_phase_gen: per-operator phase accumulators with vibrato.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fm_phase_gen
  import fm_pkg::*;
#(
  parameter int NUM_OPS      = 36,
  parameter int PHASE_BITS   = 19,
  parameter int OUT_BITS     = 10,
  parameter int VIB_DIV_LOG2 = 10,
  localparam int IDX_BITS = $clog2(NUM_OPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  fm_phase_gen_if.slave bus,
  output logic [2:0]    vib_pos
);
  phase_state_e        state_q, state_d;
  logic [IDX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic                ready, init_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_BITS'(NUM_OPS - 1)) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ready   = 1'b0;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: init_we = 1'b1;
      ST_RUN:  ready   = 1'b1;
      default: ready   = 1'b0;
    endcase
  end

  assign bus.ready = ready;

  logic [VIB_DIV_LOG2-1:0] div_q;
  logic [2:0]              vib_pos_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      vib_pos_q <= 3'd0;
    end else if (frame_tick) begin
      div_q <= div_q + 1'b1;
      if (&div_q) vib_pos_q <= vib_pos_q + 3'd1;
    end
  end

  assign vib_pos = vib_pos_q;

  logic                  accept, fwd0;
  logic [9:0]            fnum_vib;
  logic [PHASE_BITS-1:0] inc0;
  logic                  s1_valid_q, s1_restart_q, s1_fwd_q;
  logic [IDX_BITS-1:0]   s1_idx_q;
  logic [PHASE_BITS-1:0] s1_inc_q, s1_fwd_data_q;
  logic [PHASE_BITS-1:0] ram_rdata, base_acc, pre_acc, new_acc;
  logic                  out_valid_q;
  logic [IDX_BITS-1:0]   out_idx_q;
  logic [OUT_BITS-1:0]   out_phase_q;

  assign accept   = bus.in_valid & ready;
  assign fnum_vib = vib_fnum(bus.fnum, bus.vib, bus.dvb, vib_pos_q);
  assign inc0     = PHASE_BITS'(phase_inc(fnum_vib, bus.block, bus.mult));
  // The RAM read issued now misses the write stage 1 commits this cycle.
  assign fwd0     = s1_valid_q && (s1_idx_q == bus.in_idx);

  assign base_acc = s1_fwd_q ? s1_fwd_data_q : ram_rdata;
  assign pre_acc  = s1_restart_q ? '0 : base_acc;
  assign new_acc  = pre_acc + s1_inc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_restart_q  <= 1'b0;
      s1_fwd_q      <= 1'b0;
      s1_idx_q      <= '0;
      s1_inc_q      <= '0;
      s1_fwd_data_q <= '0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_phase_q   <= '0;
    end else begin
      s1_valid_q    <= accept;
      s1_fwd_data_q <= new_acc;
      if (accept) begin
        s1_idx_q     <= bus.in_idx;
        s1_restart_q <= bus.restart;
        s1_inc_q     <= inc0;
        s1_fwd_q     <= fwd0;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_idx_q   <= s1_idx_q;
        out_phase_q <= pre_acc[PHASE_BITS-1 -: OUT_BITS];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_phase = out_phase_q;

  logic                  ram_we;
  logic [IDX_BITS-1:0]   ram_waddr;
  logic [PHASE_BITS-1:0] ram_wdata;

  // The pipeline is always empty during the sweep, so the ports never collide.
  assign ram_we    = init_we | s1_valid_q;
  assign ram_waddr = init_we ? init_cnt_q : s1_idx_q;
  assign ram_wdata = init_we ? '0 : new_acc;

  fm_phase_ram #(
    .DEPTH     (NUM_OPS),
    .WIDTH     (PHASE_BITS),
    .ADDR_BITS (IDX_BITS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (bus.in_idx),
    .rdata_o (ram_rdata)
  );
endmodule
`default_nettype wire

// File: tb/tb_fm_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fm_phase_gen: scoreboard bench for the phase generator.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fm_phase_gen;
  localparam int NUM_OPS      = 36;
  localparam int PHASE_BITS   = 19;
  localparam int OUT_BITS     = 10;
  localparam int VIB_DIV_LOG2 = 10;
  localparam int IDX_BITS     = $clog2(NUM_OPS);
  localparam int PMASK        = (1 << PHASE_BITS) - 1;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] vib_pos;

  fm_phase_gen_if #(.NUM_OPS(NUM_OPS), .OUT_BITS(OUT_BITS)) bus ();

  fm_phase_gen #(
    .NUM_OPS      (NUM_OPS),
    .PHASE_BITS   (PHASE_BITS),
    .OUT_BITS     (OUT_BITS),
    .VIB_DIV_LOG2 (VIB_DIV_LOG2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .bus        (bus),
    .vib_pos    (vib_pos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct { int idx; int phase; int cyc; } exp_t;
  exp_t sbq[$];

  int m_acc [NUM_OPS];
  int m_div  = 0;
  int m_vpos = 0;
  int mult_tab [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

  function automatic int model_fnum(int f, int vib, int dvb, int pos);
    int r;
    r = (f >> 7) & 7;
    if (vib == 0 || (pos & 3) == 0) r = 0;
    else if ((pos & 1) != 0) r = r >> 1;
    if (dvb == 0) r = r >> 1;
    return ((pos & 4) != 0) ? ((f - r) & 'h3FF) : ((f + r) & 'h3FF);
  endfunction

  function automatic int model_inc(int f, int blk, int mult);
    int fw;
    fw = (f << blk) & 'h1FFFF;
    return (((fw >> 1) * mult_tab[mult]) >> 1) & PMASK;
  endfunction

  task automatic model_frame_tick();
    m_div = (m_div + 1) % (1 << VIB_DIV_LOG2);
    if (m_div == 0) m_vpos = (m_vpos + 1) % 8;
  endtask

  // Advance one cycle and retire any result the DUT presents.
  task automatic tick_cycle();
    exp_t e;
    @(negedge clk);
    if (!reset && bus.out_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got idx=%0d phase=0x%0h required no output",
                 bus.out_idx, bus.out_phase);
      end else begin
        e = sbq.pop_front();
        if (bus.out_idx !== IDX_BITS'(e.idx) || bus.out_phase !== OUT_BITS'(e.phase) ||
            cyc != e.cyc) begin
          failures++;
          $display("FAIL sb_output got idx=%0d phase=0x%0h cyc=%0d required idx=%0d phase=0x%0h cyc=%0d",
                   bus.out_idx, bus.out_phase, cyc, e.idx, e.phase, e.cyc);
        end
      end
    end
  endtask

  task automatic send(input int idx, input int rs, input int f, input int blk,
                      input int mult, input int vib, input int dvb, input int tick);
    int   fv, inc, pre;
    exp_t e;
    tick_cycle();
    bus.in_valid = 1'b1;
    bus.in_idx   = IDX_BITS'(idx);
    bus.restart  = (rs != 0);
    bus.fnum     = 10'(f);
    bus.block    = 3'(blk);
    bus.mult     = 4'(mult);
    bus.vib      = (vib != 0);
    bus.dvb      = (dvb != 0);
    frame_tick   = (tick != 0);
    if (bus.ready === 1'b1) begin
      fv  = model_fnum(f, vib, dvb, m_vpos);
      inc = model_inc(fv, blk, mult);
      pre = (rs != 0) ? 0 : m_acc[idx];
      e.idx   = idx;
      e.phase = (pre >> (PHASE_BITS - OUT_BITS)) & ((1 << OUT_BITS) - 1);
      e.cyc   = cyc + 2;
      sbq.push_back(e);
      m_acc[idx] = (pre + inc) & PMASK;
    end
    if (tick != 0) model_frame_tick();
  endtask

  task automatic idle();
    tick_cycle();
    bus.in_valid = 1'b0;
    bus.restart  = 1'b0;
    frame_tick   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sbq.size() > 0; i++) tick_cycle();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick_cycle();
      n++;
      if (bus.ready === 1'b1) begin
        bus.in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic model_clear();
    foreach (m_acc[i]) m_acc[i] = 0;
    m_div  = 0;
    m_vpos = 0;
    sbq.delete();
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_idx = '0; bus.restart = 1'b0; bus.fnum = '0;
    bus.block = '0; bus.mult = '0; bus.vib = 1'b0; bus.dvb = 1'b0;
    for (int i = 0; i < 3; i++) tick_cycle();
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rst_ready got %b required 0", bus.ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b required 0", bus.out_valid); end
    checks++; if (bus.out_idx !== '0) begin failures++; $display("FAIL rst_out_idx got %0d required 0", bus.out_idx); end
    checks++; if (bus.out_phase !== '0) begin failures++; $display("FAIL rst_out_phase got %0d required 0", bus.out_phase); end
    checks++; if (vib_pos !== 3'd0) begin failures++; $display("FAIL rst_vib_pos got %0d required 0", vib_pos); end
    // Requests held across reset release and INIT must be dropped.
    bus.in_valid = 1'b1; bus.in_idx = IDX_BITS'(2); bus.fnum = 10'h3FF; bus.block = 3'd7; bus.mult = 4'd15;
    reset = 1'b0;
    wait_ready(n);
    model_clear();
    checks++; if (n != NUM_OPS) begin failures++; $display("FAIL init_len got %0d required %0d", n, NUM_OPS); end
    for (int i = 0; i < NUM_OPS; i++) begin
      checks++;
      if (dut.u_ram.mem_q[i] !== PHASE_BITS'(0)) begin
        failures++; $display("FAIL init_acc[%0d] got 0x%0h required 0", i, dut.u_ram.mem_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) tick_cycle();
  endtask

  task automatic test_increment();
    for (int i = 0; i < 5; i++) send(3, 0, 'h200, 4, 1, 0, 0, 0);
    idle(); drain();
    checks++;
    if (dut.u_ram.mem_q[3] !== PHASE_BITS'('h5000)) begin
      failures++; $display("FAIL inc_acc got 0x%0h required 0x5000", dut.u_ram.mem_q[3]);
    end
  endtask

  task automatic test_restart();
    send(5, 0, 'h200, 4, 1, 0, 0, 0);
    send(5, 0, 'h200, 4, 1, 0, 0, 0);
    send(5, 1, 'h100, 0, 0, 0, 0, 0);
    idle(); drain();
    checks++;
    if (dut.u_ram.mem_q[5] !== PHASE_BITS'('h40)) begin
      failures++; $display("FAIL restart_acc got 0x%0h required 0x40", dut.u_ram.mem_q[5]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) send(7, 0, 'h200, 2, 0, 0, 0, 0);
    idle(); drain();
    for (int i = 0; i < 3; i++) begin
      send(8, 0, 'h200, 2, 0, 0, 0, 0);
      idle(); tick_cycle(); tick_cycle();
    end
    drain();
    checks++;
    if (dut.u_ram.mem_q[7] !== PHASE_BITS'('h600)) begin
      failures++; $display("FAIL hazard_acc got 0x%0h required 0x600", dut.u_ram.mem_q[7]);
    end
    checks++;
    if (dut.u_ram.mem_q[8] !== PHASE_BITS'('h600)) begin
      failures++; $display("FAIL spaced_acc got 0x%0h required 0x600", dut.u_ram.mem_q[8]);
    end
  endtask

  // inc = f_num<<9 here, so a follow-up zero-inc read shows f_num on out_phase.
  task automatic test_vibrato();
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (vib_pos !== 3'(m_vpos)) begin
        failures++; $display("FAIL vib_pos got %0d required %0d", vib_pos, m_vpos);
      end
      send(9, 1, 'h380, 7, 8, 1, 1, 0);
      send(9, 0, 0, 0, 0, 0, 0, 0);
      send(10, 1, 'h380, 7, 8, 1, 0, 0);
      send(10, 0, 0, 0, 0, 0, 0, 0);
      idle(); drain();
      for (int i = 0; i < (1 << VIB_DIV_LOG2) - 1; i++) begin
        tick_cycle();
        frame_tick = 1'b1;
        model_frame_tick();
      end
      send(11, 0, 'h380, 7, 8, 1, 1, 1);
      idle(); drain();
    end
    checks++;
    if (vib_pos !== 3'd0) begin
      failures++; $display("FAIL vib_wrap got %0d required 0", vib_pos);
    end
  endtask

  task automatic test_wrap_reset();
    int n;
    send(12, 1, 'h200, 7, 8, 0, 0, 0);
    send(12, 0, 'h1FF, 7, 8, 0, 0, 0);
    send(12, 0, 'h3FC, 0, 0, 0, 0, 0);
    send(12, 0, 'h3FC, 0, 0, 0, 0, 0);
    send(12, 0, 4, 0, 0, 0, 0, 0);
    idle(); drain();
    checks++;
    if (dut.u_ram.mem_q[12] !== PHASE_BITS'('h7FFFF)) begin
      failures++; $display("FAIL preload_acc got 0x%0h required 0x7ffff", dut.u_ram.mem_q[12]);
    end
    send(12, 0, 4, 0, 0, 0, 0, 0);
    idle(); drain();
    checks++;
    if (dut.u_ram.mem_q[12] !== PHASE_BITS'(0)) begin
      failures++; $display("FAIL wrap_acc got 0x%0h required 0", dut.u_ram.mem_q[12]);
    end
    for (int i = 0; i < (1 << VIB_DIV_LOG2); i++) begin
      tick_cycle();
      frame_tick = 1'b1;
      model_frame_tick();
    end
    idle();
    checks++;
    if (vib_pos !== 3'(m_vpos)) begin
      failures++; $display("FAIL pre_rst_vib_pos got %0d required %0d", vib_pos, m_vpos);
    end
    send(13, 0, 'h200, 4, 1, 0, 0, 0);
    send(14, 0, 'h200, 4, 1, 0, 0, 0);
    tick_cycle();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) tick_cycle();
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got %b required 0", bus.ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got %b required 0", bus.out_valid); end
    reset = 1'b0;
    wait_ready(n);
    checks++; if (n != NUM_OPS) begin failures++; $display("FAIL reinit_len got %0d required %0d", n, NUM_OPS); end
    checks++; if (vib_pos !== 3'd0) begin failures++; $display("FAIL reinit_vib_pos got %0d required 0", vib_pos); end
    for (int i = 0; i < NUM_OPS; i++) begin
      checks++;
      if (dut.u_ram.mem_q[i] !== PHASE_BITS'(0)) begin
        failures++; $display("FAIL reinit_acc[%0d] got 0x%0h required 0", i, dut.u_ram.mem_q[i]);
      end
    end
    send(13, 0, 'h200, 4, 1, 0, 0, 0);
    send(13, 0, 'h200, 4, 1, 0, 0, 0);
    idle(); drain();
  endtask

  initial begin
    test_reset();
    test_increment();
    test_restart();
    test_back_to_back();
    test_vibrato();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
